// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch front end with 2-entry {pc, instr} prefetch buffer
module fetch_stage #(
    parameter int              ADDR_W    = 16,
    parameter int              DATA_W    = 16,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter logic [DATA_W-1:0] NOP_INSTR = '0
) (
    input  logic              clk,
    input  logic              resetn,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_rd_en,
    input  logic [DATA_W-1:0] imem_rd_data,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [DATA_W-1:0] if_instr,
    output logic [ADDR_W-1:0] if_pc,
    output logic              if_valid
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] tag_q, tag_d;
    logic [ADDR_W-1:0] last_pc_q;
    logic              inflight_q, inflight_d;
    logic [1:0]        count_q, count_d;
    logic              head_q, head_d;
    logic [ADDR_W-1:0] buf_pc_q    [2];
    logic [DATA_W-1:0] buf_instr_q [2];

    logic       pop;
    logic       push;
    logic       issue;
    logic       wr_idx;
    logic [2:0] occupancy;

    assign if_valid = (count_q != 2'd0);
    assign if_pc    = if_valid ? buf_pc_q[head_q]    : last_pc_q;
    assign if_instr = if_valid ? buf_instr_q[head_q] : NOP_INSTR;

    assign pop       = if_valid & ~stall & ~redirect;
    assign push      = inflight_q & ~redirect;
    // An arriving response only ever sees count <= 1, so head+count picks a free slot.
    assign wr_idx    = head_q ^ count_q[0];
    assign occupancy = {1'b0, count_q} - {2'b00, pop} + {2'b00, inflight_q};
    assign issue     = (occupancy <= 3'd1);

    assign imem_rd_en = resetn & (redirect | issue);
    assign imem_addr  = redirect ? redirect_pc : pc_q;

    always_comb begin
        pc_d       = pc_q;
        tag_d      = tag_q;
        inflight_d = 1'b0;
        count_d    = count_q;
        head_d     = head_q;
        if (redirect) begin
            pc_d       = redirect_pc + 1'b1;
            tag_d      = redirect_pc;
            inflight_d = 1'b1;
            count_d    = 2'd0;
            head_d     = 1'b0;
        end else begin
            count_d = count_q + {1'b0, push} - {1'b0, pop};
            if (pop) begin
                head_d = ~head_q;
            end
            if (issue) begin
                pc_d       = pc_q + 1'b1;
                tag_d      = pc_q;
                inflight_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc_q           <= RESET_PC;
            tag_q          <= RESET_PC;
            last_pc_q      <= RESET_PC;
            inflight_q     <= 1'b0;
            count_q        <= 2'd0;
            head_q         <= 1'b0;
            buf_pc_q[0]    <= RESET_PC;
            buf_pc_q[1]    <= RESET_PC;
            buf_instr_q[0] <= NOP_INSTR;
            buf_instr_q[1] <= NOP_INSTR;
        end else begin
            pc_q       <= pc_d;
            tag_q      <= tag_d;
            last_pc_q  <= if_pc;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            head_q     <= head_d;
            if (push) begin
                buf_pc_q[wr_idx]    <= tag_q;
                buf_instr_q[wr_idx] <= imem_rd_data;
            end
        end
    end

endmodule
